// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and control-transfer sequencer.
// Stalls/flushes for taken branches, load-use, RET/RTI and interrupt entry.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] id_rs,
  input  logic [1:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_ret,
  input  logic [1:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       irq,
  input  logic       int_enable,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       pc_load_ret,
  output logic       pc_load_vec,
  output logic       int_ack,
  output logic       busy
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    INT_SEQ  = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] cnt;
  logic       irq_pending;

  logic       load_use;
  logic       run;
  logic       in_seq;
  logic       seq_last;
  logic       take_br;
  logic       take_lu;
  logic       take_ret;
  logic       take_int;

  // load in EX whose destination feeds an operand read in ID
  always_comb begin
    load_use = ex_mem_read & ex_reg_write &
               ((id_uses_rs & (ex_rd == id_rs)) |
                (id_uses_rt & (ex_rd == id_rt)));
  end

  // mutually exclusive event selects; reset masks everything
  always_comb begin
    run      = ~rst & (state == RUN);
    in_seq   = ~rst & (state != RUN);
    seq_last = in_seq & (cnt <= 2'd1);
    take_br  = run & ex_branch_taken;
    take_lu  = run & ~ex_branch_taken & load_use;
    take_ret = run & ~ex_branch_taken & ~load_use & id_is_ret;
    take_int = run & ~ex_branch_taken & ~load_use & ~id_is_ret &
               irq_pending & int_enable;
  end

  // control output decode
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pc_load_ret = 1'b0;
    pc_load_vec = 1'b0;
    int_ack     = 1'b0;
    busy        = in_seq;
    unique case (1'b1)
      take_br: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      take_lu: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
      take_ret: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
      end
      take_int: begin
        int_ack    = 1'b1;
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      in_seq: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        pc_load_ret = seq_last & (state == RET_WAIT);
        pc_load_vec = seq_last & (state == INT_SEQ);
      end
      default: ;
    endcase
  end

  // sequencer state, wait counter and interrupt latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= 2'd0;
      irq_pending <= 1'b0;
    end else begin
      irq_pending <= irq | (irq_pending & ~take_int);
      if (state == RUN) begin
        if (take_ret) begin
          state <= RET_WAIT;
          cnt   <= 2'd2;
        end else if (take_int) begin
          state <= INT_SEQ;
          cnt   <= 2'd2;
        end
      end else begin
        cnt <= cnt - 2'd1;
        if (cnt <= 2'd1) begin
          state <= RUN;
          cnt   <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, corner-case sequences and
// randomized run against a cycle-level reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] id_rs;
  logic [1:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_is_ret;
  logic [1:0] ex_rd;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       irq;
  logic       int_enable;
  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_flush;
  logic       pc_load_ret;
  logic       pc_load_vec;
  logic       int_ack;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic en_hold = 1'b0;

  // reference model: cycles left in a sequence, its kind, latched irq
  int   m_rem  = 0;
  logic m_int  = 1'b0;
  logic m_pend = 1'b0;

  typedef struct {
    string      nm;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       mr;
    logic       br;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_ret       (id_is_ret),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .irq             (irq),
    .int_enable      (int_enable),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .pc_load_ret     (pc_load_ret),
    .pc_load_vec     (pc_load_vec),
    .int_ack         (int_ack),
    .busy            (busy)
  );

  // {pc_stall, ifid_stall, ifid_flush, idex_flush,
  //  pc_load_ret, pc_load_vec, int_ack, busy}
  function automatic logic [7:0] outs();
    return {pc_stall, ifid_stall, ifid_flush, idex_flush,
            pc_load_ret, pc_load_vec, int_ack, busy};
  endfunction

  task automatic check(input string nm, input logic [7:0] exp);
    logic [7:0] got;
    got = outs();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    id_rs           = 2'd0;
    id_rt           = 2'd0;
    id_uses_rs      = 1'b0;
    id_uses_rt      = 1'b0;
    id_is_ret       = 1'b0;
    ex_rd           = 2'd0;
    ex_reg_write    = 1'b0;
    ex_mem_read     = 1'b0;
    ex_branch_taken = 1'b0;
    irq             = 1'b0;
    int_enable      = en_hold;
  endtask

  function automatic logic lu_now();
    return ex_mem_read && ex_reg_write &&
           ((id_uses_rs && ex_rd == id_rs) ||
            (id_uses_rt && ex_rd == id_rt));
  endfunction

  function automatic logic [7:0] model_out();
    logic [7:0] e;
    if (rst) return 8'h00;
    if (m_rem > 0) begin
      e = 8'hF1;
      if (m_rem == 1) e = e | (m_int ? 8'h04 : 8'h08);
      return e;
    end
    if (ex_branch_taken) return 8'h30;
    if (lu_now()) return 8'hD0;
    if (id_is_ret) return 8'hA0;
    if (m_pend && int_enable) return 8'hB2;
    return 8'h00;
  endfunction

  task automatic model_tick();
    logic took;
    took = 1'b0;
    if (rst) begin
      m_rem  = 0;
      m_pend = 1'b0;
    end else begin
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end else if (!ex_branch_taken && !lu_now()) begin
        if (id_is_ret) begin
          m_rem = 2;
          m_int = 1'b0;
        end else if (m_pend && int_enable) begin
          m_rem = 2;
          m_int = 1'b1;
          took  = 1'b1;
        end
      end
      m_pend = irq || (m_pend && !took);
    end
  endtask

  initial begin
    tbl[0] = '{"lu_rs",    2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hD0};
    tbl[1] = '{"no_use",   2'd2, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{"lu_br",    2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h30};
    tbl[3] = '{"lu_rt",    2'd0, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hD0};
    tbl[4] = '{"no_rw",    2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[5] = '{"no_mr",    2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{"rd_miss",  2'd2, 2'd3, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[7] = '{"br_only",  2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h30};
    tbl[8] = '{"lu_r0",    2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hD0};
    tbl[9] = '{"idle",     2'd3, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    // reset with every trigger asserted
    rst             = 1'b1;
    id_rs           = 2'd1;
    id_rt           = 2'd1;
    id_uses_rs      = 1'b1;
    id_uses_rt      = 1'b1;
    id_is_ret       = 1'b1;
    ex_rd           = 2'd1;
    ex_reg_write    = 1'b1;
    ex_mem_read     = 1'b1;
    ex_branch_taken = 1'b1;
    irq             = 1'b1;
    int_enable      = 1'b1;
    #2 check("rst_out", 8'h00);
    @(negedge clk);
    #1 check("rst_hold", 8'h00);
    en_hold = 1'b1;
    step();
    rst = 1'b0;
    #1 check("post_rst", 8'h00);
    step();
    #1 check("no_stale_irq", 8'h00);

    // combinational RUN decode
    for (int i = 0; i < 10; i++) begin
      step();
      id_rs           = tbl[i].rs;
      id_rt           = tbl[i].rt;
      ex_rd           = tbl[i].rd;
      id_uses_rs      = tbl[i].urs;
      id_uses_rt      = tbl[i].urt;
      ex_reg_write    = tbl[i].rw;
      ex_mem_read     = tbl[i].mr;
      ex_branch_taken = tbl[i].br;
      #1 check(tbl[i].nm, tbl[i].exp);
    end

    // RET: accept then two wait cycles
    step(); id_is_ret = 1'b1;
    #1 check("ret_t0", 8'hA0);
    step(); ex_branch_taken = 1'b1;
    #1 check("ret_t1", 8'hF1);
    step(); id_is_ret = 1'b1;
    #1 check("ret_t2", 8'hF9);
    step();
    #1 check("ret_t3", 8'h00);

    // irq latched while disabled, taken once enabled
    en_hold = 1'b0;
    step(); irq = 1'b1;
    #1 check("irq_t0", 8'h00);
    for (int i = 1; i < 5; i++) begin
      step();
      #1 check("irq_masked", 8'h00);
    end
    en_hold = 1'b1;
    step();
    #1 check("irq_t5_ack", 8'hB2);
    step();
    #1 check("irq_t6", 8'hF1);
    step();
    #1 check("irq_t7_vec", 8'hF5);
    step();
    #1 check("irq_t8_clr", 8'h00);

    // irq during RET_WAIT
    step(); id_is_ret = 1'b1;
    #1 check("rw_t0", 8'hA0);
    step(); irq = 1'b1;
    #1 check("rw_t1", 8'hF1);
    step();
    #1 check("rw_t2_ret", 8'hF9);
    step();
    #1 check("rw_t3_ack", 8'hB2);
    step();
    #1 check("rw_t4", 8'hF1);
    step();
    #1 check("rw_t5_vec", 8'hF5);
    step();
    #1 check("rw_t6", 8'h00);

    // irq coinciding with the pending clear re-arms it
    step(); irq = 1'b1;
    #1 check("sw_t0", 8'h00);
    step(); irq = 1'b1;
    #1 check("sw_ack1", 8'hB2);
    step();
    #1 check("sw_w1", 8'hF1);
    step();
    #1 check("sw_vec1", 8'hF5);
    step();
    #1 check("sw_ack2", 8'hB2);
    step();
    #1 check("sw_w2", 8'hF1);
    step();
    #1 check("sw_vec2", 8'hF5);
    step();
    #1 check("sw_idle", 8'h00);

    // async reset in INT_SEQ aborts with no vector load
    step(); irq = 1'b1;
    #1 check("ar_t0", 8'h00);
    step();
    #1 check("ar_ack", 8'hB2);
    step();
    #1 check("ar_cnt2", 8'hF1);
    #2 rst = 1'b1;
    #1 check("ar_async", 8'h00);
    step(); id_is_ret = 1'b1; ex_branch_taken = 1'b1; irq = 1'b1;
    #1 check("ar_hold", 8'h00);
    step(); rst = 1'b0;
    #1 check("ar_release", 8'h00);
    step();
    #1 check("ar_no_vec", 8'h00);
    step();
    #1 check("ar_idle", 8'h00);

    // randomized run against the reference model
    step(); rst = 1'b1;
    #1 check("rand_rst", model_out());
    model_tick();
    for (int i = 0; i < 600; i++) begin
      step();
      rst             = ($urandom_range(0, 39) == 0);
      id_rs           = 2'($urandom_range(0, 3));
      id_rt           = 2'($urandom_range(0, 3));
      ex_rd           = 2'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_reg_write    = 1'($urandom_range(0, 1));
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      id_is_ret       = ($urandom_range(0, 5) == 0);
      irq             = ($urandom_range(0, 7) == 0);
      int_enable      = 1'($urandom_range(0, 1));
      #1 check("rand", model_out());
      model_tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; rst in 1, reset.
REQ-002 SHALL use reset rst, asynchronous, active-high; clock clk.
REQ-003 SHALL have inputs for ID-stage operands: id_rs in 2, id_rt in 2, id_uses_rs in 1, id_uses_rt in 1, id_is_ret in 1 (RET/RTI decoded in ID).
REQ-004 SHALL have inputs for EX-stage state: ex_rd in 2 (EX destination), ex_reg_write in 1, ex_mem_read in 1, ex_branch_taken in 1.
REQ-005 SHALL have interrupt inputs: irq in 1 (one-cycle request pulse) and int_enable in 1.
REQ-006 SHALL have outputs: pc_stall out 1, ifid_stall out 1, ifid_flush out 1, idex_flush out 1 (drives the ID/EX register flush input), pc_load_ret out 1, pc_load_vec out 1, int_ack out 1, busy out 1 (state != RUN).

Function
REQ-007 SHALL implement states RUN, RET_WAIT, INT_SEQ, plus a 2-bit down-counter cnt and a 1-bit irq_pending flag.
REQ-008 SHALL set irq_pending on any cycle with irq=1, and clear it only on the RUN->INT_SEQ transition; if irq=1 coincides with the clear, the set wins.
REQ-009 SHALL define load_use = ex_mem_read & ex_reg_write & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)), evaluated combinationally.
REQ-010 In RUN, outputs SHALL be combinational, in this priority: ex_branch_taken > load_use > id_is_ret > interrupt take.
REQ-011 For RUN with ex_branch_taken: ifid_flush=1 and idex_flush=1, no stall, and the block SHALL stay in RUN.
REQ-012 For RUN with load_use and no branch: pc_stall=1, ifid_stall=1, idex_flush=1 (one bubble), and the block SHALL stay in RUN; the bubble repeats while the condition holds.
REQ-013 For RUN with id_is_ret and neither of the above: pc_stall=1 and ifid_flush=1, the RET proceeds into EX, and the block SHALL go to RET_WAIT with cnt=2.
REQ-014 For RUN with irq_pending & int_enable and none of the above: int_ack=1 for one cycle, pc_stall=1, ifid_flush=1, idex_flush=1, and the block SHALL go to INT_SEQ with cnt=2.
REQ-015 In RET_WAIT: pc_stall=1, ifid_flush=1, idex_flush=1, and cnt SHALL decrement each cycle; when cnt==1, pc_load_ret=1 and the next state is RUN.
REQ-016 In INT_SEQ, behaviour SHALL be identical to RET_WAIT except pc_load_vec=1 replaces pc_load_ret.
REQ-017 In RET_WAIT and INT_SEQ, ex_branch_taken, load_use, id_is_ret and irq_pending SHALL be ignored; irq is still latched.
REQ-018 When no condition is active, all control outputs SHALL be 0.
REQ-019 pc_load_ret, pc_load_vec and int_ack SHALL each be high for exactly one cycle per sequence.
REQ-020 A RET sequence SHALL occupy 3 cycles (accept + 2 wait), and an interrupt sequence SHALL occupy 3 cycles.
REQ-021 A new sequence SHALL begin in the cycle after a return to RUN, earliest.

Reset
REQ-022 While rst=1: state=RUN, cnt=0, irq_pending=0, and all outputs SHALL be 0 irrespective of other inputs.
REQ-023 Reset asserted mid-RET_WAIT or mid-INT_SEQ SHALL abort the sequence with no load pulse issued; a pending irq SHALL be lost.
REQ-024 After rst deasserts, the first clk edge SHALL evaluate RUN normally.

Verification
REQ-025 Scenario: ex_mem_read=1, ex_reg_write=1, ex_rd=2, id_rs=2, id_uses_rs=1 -> same cycle pc_stall=1, ifid_stall=1, idex_flush=1; with id_uses_rs=0 -> all outputs 0.
REQ-026 Scenario: load_use and ex_branch_taken=1 in the same cycle -> ifid_flush=1, idex_flush=1, pc_stall=0, ifid_stall=0.
REQ-027 Scenario: id_is_ret=1 for one cycle (T0) -> T0 pc_stall=1, ifid_flush=1, idex_flush=0; T1 and T2 busy=1 with all flush/stall outputs at 1; pc_load_ret=1 only at T2; T3 busy=0.
REQ-028 Scenario: irq pulse at T0 with int_enable=0, then int_enable=1 at T5 -> int_ack=1 at T5 only, pc_load_vec=1 at T7, irq_pending=0 from T6.
REQ-029 Scenario: irq pulse during RET_WAIT -> RET completes with pc_load_ret, then int_ack fires in the first RUN cycle (int_enable=1).
REQ-030 Scenario: rst asserted asynchronously at INT_SEQ cnt=2 -> outputs 0 immediately, no pc_load_vec ever issued, busy=0 after release.
